innings_controller: RTL and testbench
=====================================

Name: innings_controller

Overview:
- Match-flow controller that sits downstream of the scoring block and closes the loop back into it.
- Watches the same delivery pulse and pseudorandom outcome code that the scorer consumes, and counts legal balls and overs.
- Reads both teams' packed score words, where bits [11:4] are runs and bits [3:0] are wickets.
- Decides when an innings ends and drives teamSwitch and gameOver back into the scorer; also reports the winner and ball/over progress to the display logic.

Parameters:
- OVERS_PER_INNINGS, 2, overs per innings; legal range 1..15.
- BALLS_PER_OVER, 6, legal balls per over; legal range 1..7.
- MAX_WICKETS, 10, wicket count that ends an innings.

Ports:
- clk_fpga  in  1  system clock.
- reset  in  1  synchronous, active-high.
- delivery  in  1  single-cycle pulse per bowl; the same pulse the scorer sees.
- lfsr_out  in  4  outcome code for the delivery; 13 and 14 are wide/no-ball (not legal balls).
- team1Data  in  12  team 1 packed score; [11:4] runs, [3:0] wickets.
- team2Data  in  12  team 2 packed score; same packing.
- teamSwitch  out  1  0 = team 1 batting, 1 = team 2 batting.
- gameOver  out  1  high once the match is decided; held until reset.
- winner  out  2  00 undecided, 01 team 1, 10 team 2, 11 tie.
- overs  out  4  completed overs in the current innings.
- balls  out  3  legal balls in the current over (0..BALLS_PER_OVER-1).
- last_over  out  1  present only when the optional feature is enabled.

Behaviour:
- Reset (synchronous, active-high) forces state INN1 and sets all outputs to zero: teamSwitch=0, gameOver=0, winner=00, overs=0, balls=0, last_over=0.
- States: INN1, CHK1, INN2, CHK2, DONE.

Ball counting (INN1/INN2 only):
- A delivery pulse with lfsr_out not in {13,14} is a legal ball.
- If balls==BALLS_PER_OVER-1, balls wraps to 0 and overs increments; otherwise balls increments.
- A delivery with code 13 or 14 leaves balls and overs unchanged.
- Every delivery, legal or not, moves the state to CHK1 or CHK2 for exactly one cycle. This gives one cycle of latency, because the scorer's registered team data is only updated on the delivery edge.

CHK1 (reads team1Data):
- End condition: wickets field >= MAX_WICKETS, or overs==OVERS_PER_INNINGS.
- If the end condition holds: go to INN2, set teamSwitch=1, clear balls and overs.
- Otherwise: return to INN1.

CHK2 (reads team2Data and team1Data), checked in this priority:
- Team 2 runs > team 1 runs (8-bit unsigned compare): go to DONE, winner=10.
- Else, wickets >= MAX_WICKETS or overs==OVERS_PER_INNINGS: go to DONE with winner=01 if team 1 runs > team 2 runs, otherwise 11 (equal).
- Else: return to INN2.

DONE:
- gameOver=1; winner, teamSwitch, overs and balls are frozen.
- Delivery is ignored. Only reset exits DONE.

Boundary cases:
- A delivery pulse during CHK1/CHK2 is ignored (it is not counted). Delivery pulses come from a debounced button and are never adjacent.
- The final legal ball of an innings also taking the last wicket is a single end event; only one innings transition occurs.
- The chase check has priority over the wickets/overs check, so a winning run on the last ball gives winner=10, not a tie.
- teamSwitch changes only on the CHK1→INN2 transition and never returns to 0 without reset.
- Reset asserted mid-innings or in DONE returns to INN1 on the next clock edge, regardless of whether delivery is asserted in the same cycle.

Optional Feature:
- Macro: LAST_OVER_FLAG_EN.
- When defined: the last_over output port exists and is registered high while in INN1/CHK1/INN2/CHK2 with overs==OVERS_PER_INNINGS-1. It drops on any innings transition, in DONE and on reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 12 legal deliveries with code 3 and team1Data wickets held at 0 → overs goes 0→1 after the 6th delivery; CHK1 after the 12th moves to INN2 with teamSwitch=1, overs=0, balls=0.
- In INN1, deliveries with code 13 and 14 → balls and overs unchanged, state returns to INN1, teamSwitch stays 0.
- In INN1 at overs=0, balls=3, team1Data driven to 0x05A (5 runs, 10 wickets) before the check cycle → teamSwitch=1 the cycle after CHK1.
- In INN2 with team1Data=0x320 (50 runs) and team2Data stepped to 0x330 (51 runs) → gameOver=1, winner=10 one cycle after the delivery; later deliveries change nothing.
- 2nd innings exhausts 12 balls with team1Data=0x320 and team2Data=0x323 → winner=11, gameOver=1. Repeat with team2Data=0x310 → winner=01.
- Reset asserted in DONE together with a delivery → next cycle state INN1 and all outputs zero. With LAST_OVER_FLAG_EN defined, last_over=1 exactly from the 7th through the 12th legal ball of each innings.

Source files
------------

// File: rtl/innings_controller.sv
// ============================================================================
// Module   : innings_controller
// Brief    : Match-flow FSM. Counts legal balls and overs, ends innings, and
//            decides the winner from the scorer's packed team score words.
//            Optional last-over flag output: define LAST_OVER_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module innings_controller #(
    parameter int OVERS_PER_INNINGS = 2,
    parameter int BALLS_PER_OVER    = 6,
    parameter int MAX_WICKETS       = 10
) (
    input  logic        clk_fpga,
    input  logic        reset,
    input  logic        delivery,
    input  logic [3:0]  lfsr_out,
    input  logic [11:0] team1Data,
    input  logic [11:0] team2Data,
    output logic        teamSwitch,
    output logic        gameOver,
    output logic [1:0]  winner,
    output logic [3:0]  overs,
`ifdef LAST_OVER_FLAG_EN
    output logic [2:0]  balls,
    output logic        last_over
`else
    output logic [2:0]  balls
`endif
);

    localparam logic [2:0] INN1 = 3'd0;
    localparam logic [2:0] CHK1 = 3'd1;
    localparam logic [2:0] INN2 = 3'd2;
    localparam logic [2:0] CHK2 = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [2:0] LAST_BALL     = 3'(BALLS_PER_OVER - 1);
    localparam logic [3:0] OVERS_END     = 4'(OVERS_PER_INNINGS);
    localparam logic [3:0] LAST_OVER_IDX = 4'(OVERS_PER_INNINGS - 1);
    localparam logic [3:0] WKT_LIMIT     = 4'(MAX_WICKETS);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_T1   = 2'b01;
    localparam logic [1:0] WIN_T2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] overs_nxt;
    logic [2:0] balls_nxt;
    logic       switch_nxt;
    logic       over_nxt;
    logic [1:0] winner_nxt;

    logic       legal_ball;
    logic [7:0] t1_runs;
    logic [7:0] t2_runs;
    logic [3:0] t1_wkts;
    logic [3:0] t2_wkts;

    // Codes 13 and 14 are wides/no-balls: they trigger a check but do not count.
    assign legal_ball = delivery && (lfsr_out != 4'd13) && (lfsr_out != 4'd14);
    assign t1_runs    = team1Data[11:4];
    assign t2_runs    = team2Data[11:4];
    assign t1_wkts    = team1Data[3:0];
    assign t2_wkts    = team2Data[3:0];

    always_comb begin
        state_nxt  = state;
        overs_nxt  = overs;
        balls_nxt  = balls;
        switch_nxt = teamSwitch;
        over_nxt   = gameOver;
        winner_nxt = winner;
        case (state)
            INN1, INN2: begin
                if (delivery) begin
                    if (legal_ball) begin
                        if (balls == LAST_BALL) begin
                            balls_nxt = 3'd0;
                            overs_nxt = overs + 4'd1;
                        end else begin
                            balls_nxt = balls + 3'd1;
                        end
                    end
                    // Scorer data only reflects this delivery one edge later.
                    state_nxt = (state == INN1) ? CHK1 : CHK2;
                end
            end
            CHK1: begin
                if ((t1_wkts >= WKT_LIMIT) || (overs == OVERS_END)) begin
                    state_nxt  = INN2;
                    switch_nxt = 1'b1;
                    overs_nxt  = 4'd0;
                    balls_nxt  = 3'd0;
                end else begin
                    state_nxt  = INN1;
                end
            end
            CHK2: begin
                if (t2_runs > t1_runs) begin
                    state_nxt  = DONE;
                    over_nxt   = 1'b1;
                    winner_nxt = WIN_T2;
                end else if ((t2_wkts >= WKT_LIMIT) || (overs == OVERS_END)) begin
                    state_nxt  = DONE;
                    over_nxt   = 1'b1;
                    winner_nxt = (t1_runs > t2_runs) ? WIN_T1 : WIN_TIE;
                end else begin
                    state_nxt  = INN2;
                end
            end
            DONE: begin
                over_nxt = 1'b1;
            end
            default: begin
                state_nxt = INN1;
            end
        endcase
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state      <= INN1;
            teamSwitch <= 1'b0;
            gameOver   <= 1'b0;
            winner     <= WIN_NONE;
            overs      <= 4'd0;
            balls      <= 3'd0;
        end else begin
            state      <= state_nxt;
            teamSwitch <= switch_nxt;
            gameOver   <= over_nxt;
            winner     <= winner_nxt;
            overs      <= overs_nxt;
            balls      <= balls_nxt;
        end
    end

`ifdef LAST_OVER_FLAG_EN
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            last_over <= 1'b0;
        end else begin
            last_over <= (state_nxt != DONE) && (overs_nxt == LAST_OVER_IDX);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_innings_controller.sv
// ============================================================================
// Module   : tb_innings_controller
// Brief    : Scoreboard bench for innings_controller (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_innings_controller;

    logic        clk_fpga = 1'b0;
    logic        reset;
    logic        delivery;
    logic [3:0]  lfsr_out;
    logic [11:0] team1Data;
    logic [11:0] team2Data;
    logic        teamSwitch;
    logic        gameOver;
    logic [1:0]  winner;
    logic [3:0]  overs;
    logic [2:0]  balls;
    logic        lo_bit;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string       name;
        int          cyc;
        logic [11:0] exp;
    } entry_t;

    entry_t sb[$];
    entry_t mon_e;
    logic [11:0] act;

    innings_controller dut (
        .clk_fpga   (clk_fpga),
        .reset      (reset),
        .delivery   (delivery),
        .lfsr_out   (lfsr_out),
        .team1Data  (team1Data),
        .team2Data  (team2Data),
        .teamSwitch (teamSwitch),
        .gameOver   (gameOver),
        .winner     (winner),
        .overs      (overs),
`ifdef LAST_OVER_FLAG_EN
        .balls      (balls),
        .last_over  (lo_bit)
`else
        .balls      (balls)
`endif
    );

`ifndef LAST_OVER_FLAG_EN
    assign lo_bit = 1'b0;
`endif

    always #5 clk_fpga = ~clk_fpga;

    always @(posedge clk_fpga) cyc <= cyc + 1;

    // Packed view: {teamSwitch, gameOver, winner, overs, balls, last_over}
    function automatic logic [11:0] pack(input logic sw, input logic go,
                                         input logic [1:0] win,
                                         input logic [3:0] ov,
                                         input logic [2:0] b);
        logic lo;
`ifdef LAST_OVER_FLAG_EN
        lo = (ov == 4'd1) && !go;
`else
        lo = 1'b0;
`endif
        return {sw, go, win, ov, b, lo};
    endfunction

    task automatic expect_out(input string name, input logic sw, input logic go,
                              input logic [1:0] win, input logic [3:0] ov,
                              input logic [2:0] b);
        entry_t e;
        e.name = name;
        e.cyc  = cyc;
        e.exp  = pack(sw, go, win, ov, b);
        sb.push_back(e);
    endtask

    // Monitor: compares every scoreboard entry due in the current cycle.
    always @(negedge clk_fpga) begin
        act = {teamSwitch, gameOver, winner, overs, balls, lo_bit};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != cyc || act !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: got sw/go/win/ov/b/lo=%b expected %b (cycle %0d)",
                         mon_e.name, act, mon_e.exp, cyc);
            end
        end
    end

    // Enter at posedge+1; return at posedge+1 after the check cycle resolves.
    task automatic deliver(input logic [3:0] code, input logic [11:0] t1,
                           input logic [11:0] t2, input bit hold2 = 0);
        delivery = 1'b1;
        lfsr_out = code;
        @(posedge clk_fpga); #1;
        if (!hold2) delivery = 1'b0;
        team1Data = t1;
        team2Data = t2;
        @(posedge clk_fpga); #1;
        delivery = 1'b0;
    endtask

    task automatic pulse_reset(input logic with_delivery);
        reset    = 1'b1;
        delivery = with_delivery;
        lfsr_out = 4'd3;
        @(posedge clk_fpga); #1;
        reset    = 1'b0;
        delivery = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        delivery  = 1'b0;
        lfsr_out  = 4'd0;
        team1Data = 12'h000;
        team2Data = 12'h000;
        repeat (2) @(posedge clk_fpga);
        #1;
        expect_out("reset", 0, 0, 2'b00, 4'd0, 3'd0);
        reset = 1'b0;

        deliver(4'd13, 12'h000, 12'h000);
        expect_out("wide13", 0, 0, 2'b00, 4'd0, 3'd0);
        deliver(4'd14, 12'h000, 12'h000);
        expect_out("noball14", 0, 0, 2'b00, 4'd0, 3'd0);
        deliver(4'd3, 12'h000, 12'h000, 1);
        expect_out("pulse_in_chk", 0, 0, 2'b00, 4'd0, 3'd1);

        pulse_reset(1'b0);
        expect_out("reset_mid", 0, 0, 2'b00, 4'd0, 3'd0);

        for (int i = 1; i <= 12; i++) begin
            deliver(4'd3, 12'h000, 12'h000);
            if (i < 12)
                expect_out($sformatf("inn1_ball%0d", i), 0, 0, 2'b00, 4'(i / 6), 3'(i % 6));
            else
                expect_out("inn1_overs_end", 1, 0, 2'b00, 4'd0, 3'd0);
        end

        deliver(4'd3, 12'h320, 12'h320);
        expect_out("chase_level", 1, 0, 2'b00, 4'd0, 3'd1);
        deliver(4'd3, 12'h320, 12'h330);
        expect_out("chase_win", 1, 1, 2'b10, 4'd0, 3'd2);
        deliver(4'd3, 12'h320, 12'h340);
        expect_out("done_frozen", 1, 1, 2'b10, 4'd0, 3'd2);

        pulse_reset(1'b1);
        expect_out("reset_done", 0, 0, 2'b00, 4'd0, 3'd0);

        for (int i = 1; i <= 3; i++) begin
            deliver(4'd3, 12'h000, 12'h000);
            expect_out($sformatf("pre_wkt%0d", i), 0, 0, 2'b00, 4'd0, 3'(i));
        end
        deliver(4'd3, 12'h05A, 12'h000);
        expect_out("wicket_end", 1, 0, 2'b00, 4'd0, 3'd0);

        for (int i = 1; i <= 12; i++) begin
            deliver(4'd3, 12'h320, 12'h323);
            if (i < 12)
                expect_out($sformatf("tie_ball%0d", i), 1, 0, 2'b00, 4'(i / 6), 3'(i % 6));
            else
                expect_out("tie", 1, 1, 2'b11, 4'd2, 3'd0);
        end

        pulse_reset(1'b0);
        expect_out("reset_tie", 0, 0, 2'b00, 4'd0, 3'd0);
        for (int i = 1; i <= 12; i++) begin
            deliver(4'd3, (i == 12) ? 12'h32A : 12'h320, 12'h000);
            if (i < 12)
                expect_out($sformatf("t1_ball%0d", i), 0, 0, 2'b00, 4'(i / 6), 3'(i % 6));
            else
                expect_out("last_ball_wicket", 1, 0, 2'b00, 4'd0, 3'd0);
        end
        for (int i = 1; i <= 12; i++) begin
            deliver(4'd3, 12'h320, 12'h310);
            if (i < 12)
                expect_out($sformatf("t2_ball%0d", i), 1, 0, 2'b00, 4'(i / 6), 3'(i % 6));
            else
                expect_out("team1_win", 1, 1, 2'b01, 4'd2, 3'd0);
        end

        repeat (3) @(posedge clk_fpga);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
